rx_command_collector: RTL and testbench

RX_COMMAND_COLLECTOR -- requirements
Module: rx_command_collector

---
 rtl/rx_command_collector.sv | 166 ++++++++++++++++
 tb/tb_rx_command_collector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_command_collector.sv
// ---------------------------------------------------------------------------
// rx_command_collector
//
// Purpose: gathers three consecutive bytes from a UART receiver into one
// command frame (operand A, operand B, opcode). The frame is then presented
// to a downstream ALU stage, which accepts it with i_ready. A byte is
// counted on the rising edge of the receiver's done level, so a long
// stop-bit window yields exactly one byte.
//
// Ports:
//   i_clock    - single clock
//   i_reset    - asynchronous, active-low reset
//   i_rx_data  - byte from the UART receiver (DATA_WIDTH)
//   i_rx_done  - receiver done level; may stay high for many cycles
//   i_ready    - downstream accepts the presented frame (sampled in HOLD only)
//   o_data_a   - operand A (DATA_WIDTH)
//   o_data_b   - operand B (DATA_WIDTH)
//   o_op       - opcode, low OP_WIDTH bits of the third byte
//   o_valid    - frame valid, high exactly while in HOLD
//   o_overrun  - one-cycle pulse when a byte arrives while the frame is stalled
//   o_timeout  - one-cycle pulse when a partial frame is discarded
//
// Optional feature: define RX_TIMEOUT_EN to add an inter-byte timeout of
// TIMEOUT_CYCLES clocks. Without it, o_timeout is constant 0 and a partial
// frame waits indefinitely for its remaining bytes.
// ---------------------------------------------------------------------------
module rx_command_collector #(
    parameter int DATA_WIDTH     = 8,
    parameter int OP_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data_a,
    output logic [DATA_WIDTH-1:0] o_data_b,
    output logic [OP_WIDTH-1:0]   o_op,
    output logic                  o_valid,
    output logic                  o_overrun,
    output logic                  o_timeout
);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t                state_q;
    logic                  rx_done_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic                  valid_q;
    logic                  overrun_q;
    logic                  byte_evt;
    logic                  timeout_hit;

    // Rising edge of the done level: one event per done window. The edge
    // register resets to 0, so a done level already high at release counts.
    assign byte_evt = i_rx_done & ~rx_done_q;

`ifdef RX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_q;

    // Only meaningful while a partial frame is pending; an event in the same
    // cycle takes priority in the FSM below.
    assign timeout_hit = (state_q == WAIT_B || state_q == WAIT_OP) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (byte_evt || timeout_hit || state_q == WAIT_A || state_q == HOLD) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_hit && !byte_evt;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= WAIT_A;
            rx_done_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rx_done_q <= i_rx_done;
            overrun_q <= 1'b0;
            case (state_q)
                WAIT_A: begin
                    if (byte_evt) begin
                        a_q     <= i_rx_data;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (byte_evt) begin
                        b_q     <= i_rx_data;
                        state_q <= WAIT_OP;
                    end else if (timeout_hit) begin
                        state_q <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (byte_evt) begin
                        op_q    <= i_rx_data[OP_WIDTH-1:0];
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q <= WAIT_A;
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        // Frame accepted; a coincident byte starts the next frame.
                        valid_q <= 1'b0;
                        if (byte_evt) begin
                            a_q     <= i_rx_data;
                            state_q <= WAIT_B;
                        end else begin
                            state_q <= WAIT_A;
                        end
                    end else if (byte_evt) begin
                        // Stalled frame keeps its contents; the new byte is lost.
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= WAIT_A;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_data_a  = a_q;
    assign o_data_b  = b_q;
    assign o_op      = op_q;
    assign o_valid   = valid_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_rx_command_collector.sv
module tb_rx_command_collector;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       ready;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] op;
    logic       valid;
    logic       overrun;
    logic       timeout;

    int tests_run;
    int tests_failed;
    int valid_cnt;
    int overrun_cnt;
    int timeout_cnt;

    rx_command_collector #(
        .DATA_WIDTH    (8),
        .OP_WIDTH      (6),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clock  (clk),
        .i_reset  (rst_n),
        .i_rx_data(rx_data),
        .i_rx_done(rx_done),
        .i_ready  (ready),
        .o_data_a (data_a),
        .o_data_b (data_b),
        .o_op     (op),
        .o_valid  (valid),
        .o_overrun(overrun),
        .o_timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse/level counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (valid)   valid_cnt   = valid_cnt + 1;
        if (overrun) overrun_cnt = overrun_cnt + 1;
        if (timeout) timeout_cnt = timeout_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        valid_cnt   = 0;
        overrun_cnt = 0;
        timeout_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int win, input int gap);
        rx_data = d;
        rx_done = 1'b1;
        repeat (win) tick();
        rx_done = 1'b0;
        repeat (gap) tick();
        $display("[TB] byte 0x%02h sent (window %0d)", d, win);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; rx_data = 8'h00; rx_done = 1'b0; ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check8("reset_a", data_a, 8'h00);
        check8("reset_b", data_b, 8'h00);
        check8("reset_op", {2'b00, op}, 8'h00);
        check8("reset_flags", {5'd0, valid, overrun, timeout}, 8'h00);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        $display("[TB] reset done");
    endtask

    task automatic test_basic_frame();
        ready = 1'b1;
        clear_counts();
        send_byte(8'h12, 40, 4);
        send_byte(8'h34, 40, 4);
        send_byte(8'h20, 40, 4);
        check8("basic_valid_cycles", 8'(valid_cnt), 8'd1);
        check8("basic_a", data_a, 8'h12);
        check8("basic_b", data_b, 8'h34);
        check8("basic_op", {2'b00, op}, 8'h20);
        check8("basic_valid_low_after", {7'd0, valid}, 8'd0);
        check8("basic_no_overrun", 8'(overrun_cnt), 8'd0);
        $display("[TB] basic frame A=0x%02h B=0x%02h OP=0x%02h", data_a, data_b, op);
    endtask

    task automatic test_hold_stall();
        int bad;
        ready = 1'b0;
        clear_counts();
        send_byte(8'h05, 4, 4);
        send_byte(8'h03, 4, 4);
        rx_data = 8'hE6;
        rx_done = 1'b1;
        tick();
        // The opcode edge has just been taken: valid must already be high.
        check8("stall_valid_first", {7'd0, valid}, 8'd1);
        rx_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (valid !== 1'b1 || data_a !== 8'h05 || data_b !== 8'h03 || op !== 6'h26) bad++;
        end
        check8("stall_unstable_cycles", 8'(bad), 8'd0);
        check8("stall_op_trunc", {2'b00, op}, 8'h26);
        $display("[TB] stalled frame held 100 cycles");
    endtask

    task automatic test_overrun();
        clear_counts();
        send_byte(8'h77, 6, 4);
        check8("overrun_pulses", 8'(overrun_cnt), 8'd1);
        check8("overrun_a_kept", data_a, 8'h05);
        check8("overrun_still_valid", {7'd0, valid}, 8'd1);
        ready = 1'b1;
        tick();
        check8("accept_valid_low", {7'd0, valid}, 8'd0);
        check8("accept_a_retained", data_a, 8'h05);
        $display("[TB] overrun byte dropped, frame accepted");
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        send_byte(8'h01, 4, 4);
        send_byte(8'h02, 4, 4);
        send_byte(8'h03, 4, 4);
        clear_counts();
        ready   = 1'b1;
        rx_data = 8'hAA;
        rx_done = 1'b1;
        tick();
        check8("b2b_valid_low", {7'd0, valid}, 8'd0);
        check8("b2b_a", data_a, 8'hAA);
        repeat (3) tick();
        rx_done = 1'b0;
        repeat (3) tick();
        check8("b2b_no_overrun", 8'(overrun_cnt), 8'd0);
        // Two more bytes complete the frame only if AA became operand A.
        clear_counts();
        send_byte(8'hBB, 4, 4);
        send_byte(8'h0C, 4, 4);
        check8("b2b_valid_cycles", 8'(valid_cnt), 8'd1);
        check8("b2b_b", data_b, 8'hBB);
        check8("b2b_op", {2'b00, op}, 8'h0C);
        $display("[TB] back-to-back accept+byte A=0x%02h", data_a);
    endtask

    task automatic test_reset_midframe();
        ready = 1'b1;
        send_byte(8'h11, 4, 4);
        check8("mid_a_before", data_a, 8'h11);
        #2 rst_n = 1'b0;
        #1;
        check8("mid_reset_a", data_a, 8'h00);
        check8("mid_reset_b", data_b, 8'h00);
        check8("mid_reset_op", {2'b00, op}, 8'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_counts();
        send_byte(8'h01, 4, 4);
        send_byte(8'h02, 4, 4);
        send_byte(8'h03, 4, 4);
        check8("mid_valid_cycles", 8'(valid_cnt), 8'd1);
        check8("mid_a", data_a, 8'h01);
        check8("mid_b", data_b, 8'h02);
        check8("mid_op", {2'b00, op}, 8'h03);
        $display("[TB] reset mid-frame, fresh frame collected");
    endtask

    task automatic test_done_high_at_release();
        ready = 1'b1;
        rst_n = 1'b0;
        rx_data = 8'h5A;
        rx_done = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        rx_done = 1'b0;
        repeat (2) tick();
        check8("rel_a", data_a, 8'h5A);
        clear_counts();
        send_byte(8'h6B, 4, 4);
        send_byte(8'h07, 4, 4);
        check8("rel_valid_cycles", 8'(valid_cnt), 8'd1);
        check8("rel_b", data_b, 8'h6B);
        $display("[TB] done high at reset release counted as operand A");
    endtask

    task automatic test_timeout();
        ready = 1'b1;
        clear_counts();
        send_byte(8'h01, 4, 4);
        repeat (60) tick();
`ifdef RX_TIMEOUT_EN
        check8("to_pulses", 8'(timeout_cnt), 8'd1);
        send_byte(8'h04, 4, 4);
        send_byte(8'h05, 4, 4);
        send_byte(8'h06, 4, 4);
        check8("to_valid_cycles", 8'(valid_cnt), 8'd1);
        check8("to_a", data_a, 8'h04);
        check8("to_b", data_b, 8'h05);
        check8("to_op", {2'b00, op}, 8'h06);
`else
        check8("to_pulses", 8'(timeout_cnt), 8'd0);
        send_byte(8'h02, 4, 4);
        send_byte(8'h03, 4, 4);
        check8("to_valid_cycles", 8'(valid_cnt), 8'd1);
        check8("to_a", data_a, 8'h01);
        check8("to_b", data_b, 8'h02);
        check8("to_op", {2'b00, op}, 8'h03);
`endif
        $display("[TB] idle partial frame handled");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clear_counts();
        test_reset();
        test_basic_frame();
        test_hold_stall();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        test_done_high_at_release();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
